// File: rtl/hdc_pkg.sv
// Types shared by the hypervector compute kernel and its result streamer.
package hdc_pkg;

   localparam int ELEMENT_WIDTH_DEFAULT = 64;

   typedef logic [ELEMENT_WIDTH_DEFAULT-1:0] hv_elem_t;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } streamer_state_e;

endpackage

// File: rtl/hv_result_streamer.sv
// Snapshots the kernel's result hypervector on done and drains it one element per
// valid/ready beat, so the kernel can start its next operation immediately.
module hv_result_streamer
   import hdc_pkg::*;
#(
   parameter int HYPERVECTOR_DIMENSIONS = 100,
   parameter int ELEMENT_WIDTH          = ELEMENT_WIDTH_DEFAULT,
   localparam int INDEX_BITS = (HYPERVECTOR_DIMENSIONS > 1) ? $clog2(HYPERVECTOR_DIMENSIONS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     done,
   input  logic [ELEMENT_WIDTH-1:0] hvecRes [HYPERVECTOR_DIMENSIONS],
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ELEMENT_WIDTH-1:0] out_data,
   output logic [INDEX_BITS-1:0]    out_index,
   output logic                     out_last,
   output logic                     busy,
   output logic                     overrun
);

   // Handshake: a beat transfers on a rising edge where out_valid && out_ready.
   // While out_valid && !out_ready every out_* signal holds its value.
   localparam int D = HYPERVECTOR_DIMENSIONS;
   localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(D - 1);

   streamer_state_e          state_q, state_d;
   logic [INDEX_BITS-1:0]    index_q, index_d;
   logic                     overrun_q, overrun_d;
   logic [ELEMENT_WIDTH-1:0] snap_q [D];
   logic                     handshake;
   logic                     final_beat;
   logic                     capture;

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      overrun_d  = overrun_q;
      capture    = 1'b0;
      handshake  = (state_q == STREAM) && out_ready;
      final_beat = handshake && (index_q == LAST_IDX);
      case (state_q)
         IDLE: begin
            if (done) begin
               capture = 1'b1;
               state_d = STREAM;
               index_d = '0;
            end
         end
         STREAM: begin
            if (final_beat) begin
               // A done arriving with the last beat restarts without a bubble.
               index_d = '0;
               if (done) capture = 1'b1;
               else      state_d = IDLE;
            end else begin
               if (handshake) index_d = index_q + INDEX_BITS'(1);
               if (done)      overrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         index_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         overrun_q <= overrun_d;
      end
   end

   // Snapshot contents are don't-care out of reset, so no reset term here.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < D; i++) snap_q[i] <= hvecRes[i];
      end
   end

   assign out_valid = (state_q == STREAM);
   assign busy      = (state_q == STREAM);
   assign out_index = index_q;
   assign out_last  = (state_q == STREAM) && (index_q == LAST_IDX);
   assign out_data  = (state_q == STREAM) ? snap_q[index_q] : '0;
   assign overrun   = overrun_q;

endmodule
